// File: rtl/text_terminal_writer_if.sv
// Character source and tile-RAM write port of the text terminal writer.
// The slave side is the writer; the master side is the character source / RAM observer.
interface text_terminal_writer_if;
  logic [6:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic        we;
  logic [11:0] addr_w;
  logic [6:0]  din;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic        busy;

  modport master (
    output char_in, char_valid,
    input  char_ready, we, addr_w, din, cur_x, cur_y, busy
  );

  modport slave (
    input  char_in, char_valid,
    output char_ready, we, addr_w, din, cur_x, cur_y, busy
  );
endinterface

// File: rtl/text_terminal_writer.sv
// Turns a stream of ASCII codes into tile-RAM writes, tracking the cursor and
// handling CR/LF/BS/FF plus line and full-screen clears.
module text_terminal_writer #(
  parameter int unsigned MAX_X = 80,
  parameter int unsigned MAX_Y = 30,
  parameter logic [6:0]  BLANK = 7'h20
) (
  input logic                   i_clk,
  input logic                   i_reset,
  text_terminal_writer_if.slave io_bus
);

  localparam logic [6:0] LastCol = 7'(MAX_X - 1);
  localparam logic [4:0] LastRow = 5'(MAX_Y - 1);

  typedef enum logic [1:0] {StClrScreen, StClrLine, StIdle} state_e;

  state_e      r_state, w_state_d;
  logic [6:0]  r_cur_x, w_cur_x_d;
  logic [4:0]  r_cur_y, w_cur_y_d;
  logic [6:0]  r_clr_col, w_clr_col_d;
  logic [4:0]  r_clr_row, w_clr_row_d;
  logic        r_we, w_we_d;
  logic [11:0] r_addr, w_addr_d;
  logic [6:0]  r_din, w_din_d;
  logic        w_ready;
  logic        w_accept;
  logic [6:0]  w_char;

  function automatic logic [4:0] next_row(input logic [4:0] row);
    return (row == LastRow) ? 5'd0 : row + 5'd1;
  endfunction

  assign w_ready  = (r_state == StIdle) && !i_reset;
  assign w_accept = w_ready && io_bus.char_valid;
  assign w_char   = io_bus.char_in;

  always_comb begin
    w_state_d   = r_state;
    w_cur_x_d   = r_cur_x;
    w_cur_y_d   = r_cur_y;
    w_clr_col_d = r_clr_col;
    w_clr_row_d = r_clr_row;
    w_we_d      = 1'b0;
    w_addr_d    = r_addr;
    w_din_d     = r_din;
    unique case (r_state)
      StClrScreen: begin
        w_we_d   = 1'b1;
        w_addr_d = {r_clr_row, r_clr_col};
        w_din_d  = BLANK;
        if (r_clr_col == LastCol) begin
          w_clr_col_d = 7'd0;
          if (r_clr_row == LastRow) begin
            w_clr_row_d = 5'd0;
            w_state_d   = StIdle;
          end else begin
            w_clr_row_d = r_clr_row + 5'd1;
          end
        end else begin
          w_clr_col_d = r_clr_col + 7'd1;
        end
      end
      StClrLine: begin
        w_we_d   = 1'b1;
        w_addr_d = {r_cur_y, r_clr_col};
        w_din_d  = BLANK;
        if (r_clr_col == LastCol) begin
          w_clr_col_d = 7'd0;
          w_state_d   = StIdle;
        end else begin
          w_clr_col_d = r_clr_col + 7'd1;
        end
      end
      StIdle: begin
        if (w_accept) begin
          if (w_char >= 7'h20 && w_char <= 7'h7E) begin
            // The character write is registered here, so it leaves before any wrap clear.
            w_we_d   = 1'b1;
            w_addr_d = {r_cur_y, r_cur_x};
            w_din_d  = w_char;
            if (r_cur_x == LastCol) begin
              w_cur_x_d   = 7'd0;
              w_cur_y_d   = next_row(r_cur_y);
              w_clr_col_d = 7'd0;
              w_state_d   = StClrLine;
            end else begin
              w_cur_x_d = r_cur_x + 7'd1;
            end
          end else begin
            case (w_char)
              7'h0D: w_cur_x_d = 7'd0;
              7'h0A: begin
                w_cur_x_d   = 7'd0;
                w_cur_y_d   = next_row(r_cur_y);
                w_clr_col_d = 7'd0;
                w_state_d   = StClrLine;
              end
              7'h08: begin
                if (r_cur_x != 7'd0) begin
                  w_cur_x_d = r_cur_x - 7'd1;
                  w_we_d    = 1'b1;
                  w_addr_d  = {r_cur_y, r_cur_x - 7'd1};
                  w_din_d   = BLANK;
                end
              end
              7'h0C: begin
                w_cur_x_d   = 7'd0;
                w_cur_y_d   = 5'd0;
                w_clr_col_d = 7'd0;
                w_clr_row_d = 5'd0;
                w_state_d   = StClrScreen;
              end
              default: ;
            endcase
          end
        end
      end
      default: w_state_d = StClrScreen;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StClrScreen;
      r_cur_x   <= 7'd0;
      r_cur_y   <= 5'd0;
      r_clr_col <= 7'd0;
      r_clr_row <= 5'd0;
      r_we      <= 1'b0;
      r_addr    <= 12'd0;
      r_din     <= BLANK;
    end else begin
      r_state   <= w_state_d;
      r_cur_x   <= w_cur_x_d;
      r_cur_y   <= w_cur_y_d;
      r_clr_col <= w_clr_col_d;
      r_clr_row <= w_clr_row_d;
      r_we      <= w_we_d;
      r_addr    <= w_addr_d;
      r_din     <= w_din_d;
    end
  end

  assign io_bus.char_ready = w_ready;
  assign io_bus.busy       = (r_state != StIdle) || i_reset;
  assign io_bus.we         = r_we;
  assign io_bus.addr_w     = r_addr;
  assign io_bus.din        = r_din;
  assign io_bus.cur_x      = r_cur_x;
  assign io_bus.cur_y      = r_cur_y;

endmodule

// File: tb/tb_text_terminal_writer.sv
// Directed and random character streams against a screen/cursor model; every RAM
// write is matched in order against the writes the model predicts.
module tb_text_terminal_writer;

  localparam int Cols = 80;
  localparam int Rows = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  text_terminal_writer_if bus();

  text_terminal_writer #(.MAX_X(80), .MAX_Y(30), .BLANK(7'h20)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .io_bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_wr  = 0;
  int n_bad = 0;
  int mx = 0;
  int my = 0;
  int hits[4096];
  logic [6:0]  ram[4096];
  logic [6:0]  scr[4096];
  logic [18:0] expq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe the RAM port shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (bus.we === 1'b1) begin
      n_wr++;
      if (int'(bus.addr_w[6:0]) >= Cols || int'(bus.addr_w[11:7]) >= Rows) n_bad++;
      ram[bus.addr_w] = bus.din;
      hits[bus.addr_w]++;
      if (expq.size() == 0) chk("write_unexpected", {1'b1, bus.addr_w, bus.din}, 32'h0);
      else chk("write", {bus.addr_w, bus.din}, expq.pop_front());
    end
  end

  task automatic push_w(input int a, input logic [6:0] d);
    logic [11:0] a12;
    a12 = a[11:0];
    expq.push_back({a12, d});
    scr[a] = d;
  endtask

  task automatic clear_line();
    for (int c = 0; c < Cols; c++) push_w(my * 128 + c, 7'h20);
  endtask

  task automatic clear_screen();
    for (int r = 0; r < Rows; r++)
      for (int c = 0; c < Cols; c++) push_w(r * 128 + c, 7'h20);
  endtask

  task automatic advance_row();
    my = (my + 1) % Rows;
  endtask

  task automatic model_char(input logic [6:0] ch);
    if (ch >= 7'h20 && ch <= 7'h7E) begin
      push_w(my * 128 + mx, ch);
      if (mx == Cols - 1) begin
        mx = 0;
        advance_row();
        clear_line();
      end else mx++;
    end else if (ch == 7'h0D) mx = 0;
    else if (ch == 7'h0A) begin
      mx = 0;
      advance_row();
      clear_line();
    end else if (ch == 7'h08) begin
      if (mx > 0) begin
        mx--;
        push_w(my * 128 + mx, 7'h20);
      end
    end else if (ch == 7'h0C) begin
      mx = 0;
      my = 0;
      clear_screen();
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input logic [6:0] ch);
    int w;
    w = 0;
    bus.char_in    = ch;
    bus.char_valid = 1'b1;
    while (bus.char_ready !== 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (bus.char_ready !== 1'b1) chk("ready_timeout", {31'b0, bus.char_ready}, 32'h1);
    model_char(ch);
    @(negedge clk);
    bus.char_valid = 1'b0;
    chk("cursor", {bus.cur_y, bus.cur_x}, {my[4:0], mx[6:0]});
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (bus.char_ready !== 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", {31'b0, bus.char_ready}, 32'h1);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    bus.char_valid = 1'b0;
    expq.delete();
    mx = 0;
    my = 0;
    repeat (cycles) @(negedge clk);
    chk("rst_we", {31'b0, bus.we}, 32'h0);
    chk("rst_ready", {31'b0, bus.char_ready}, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'h1);
    chk("rst_cur", {bus.cur_y, bus.cur_x}, 32'h0);
    chk("rst_addr", {20'b0, bus.addr_w}, 32'h0);
    chk("rst_din", {25'b0, bus.din}, 32'h20);
    rst = 1'b0;
    clear_screen();
    @(negedge clk);
    chk("first_clear_write", {bus.we, bus.addr_w, bus.din}, {1'b1, 12'h000, 7'h20});
  endtask

  initial begin
    int ok;
    int diff;
    int r;
    logic [6:0] ch;
    bus.char_in    = 7'h00;
    bus.char_valid = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      hits[i] = 0;
      ram[i]  = 7'h00;
      scr[i]  = 7'h00;
    end

    // Power-up clear: exactly one blank per valid cell.
    @(negedge clk);
    do_reset(3);
    repeat (2399) @(negedge clk);
    chk("clear_writes", n_wr, 2400);
    ok = 0;
    for (int y = 0; y < Rows; y++)
      for (int x = 0; x < Cols; x++) if (hits[y * 128 + x] == 1) ok++;
    chk("clear_coverage", ok, 2400);
    chk("ready_after_clear", {31'b0, bus.char_ready}, 32'h1);
    chk("cursor_after_clear", {bus.cur_y, bus.cur_x}, 32'h0);

    // Back-to-back "A","B".
    send(7'h41);
    chk("a_write", {bus.we, bus.addr_w, bus.din}, {1'b1, 12'h000, 7'h41});
    chk("a_ready", {31'b0, bus.char_ready}, 32'h1);
    send(7'h42);
    chk("b_write", {bus.we, bus.addr_w, bus.din}, {1'b1, 12'h001, 7'h42});
    @(negedge clk);
    chk("we_one_cycle", {31'b0, bus.we}, 32'h0);
    chk("ab_cursor", {bus.cur_y, bus.cur_x}, {5'd0, 7'd2});

    // Full row of printables wraps and clears row 1.
    send(7'h0D);
    for (int i = 0; i < Cols; i++) send(7'(8'h21 + (i % 94)));
    chk("wrap_last_write", {bus.we, bus.addr_w}, {1'b1, 5'd0, 7'd79});
    chk("wrap_cursor", {bus.cur_y, bus.cur_x}, {5'd1, 7'd0});
    ok = 0;
    for (int i = 0; i < Cols; i++) begin
      @(negedge clk);
      if (bus.we === 1'b1 && bus.addr_w === {5'd1, 7'(i)} && bus.din === 7'h20 &&
          (i == Cols - 1 || bus.char_ready === 1'b0)) ok++;
    end
    chk("wrap_line_clear", ok, Cols);
    chk("wrap_ready_back", {31'b0, bus.char_ready}, 32'h1);

    // LF on the last row wraps to row 0.
    for (int i = 0; i < 28; i++) send(7'h0A);
    for (int i = 0; i < 5; i++) send(7'h78);
    chk("pre_lf_cursor", {bus.cur_y, bus.cur_x}, {5'd29, 7'd5});
    send(7'h0A);
    chk("lf_cursor", {bus.cur_y, bus.cur_x}, 32'h0);
    chk("lf_busy", {31'b0, bus.busy}, 32'h1);

    // Backspace at column 0 and column 4, then DEL.
    for (int i = 0; i < 3; i++) send(7'h0A);
    send(7'h08);
    chk("bs_col0_nowrite", {31'b0, bus.we}, 32'h0);
    chk("bs_col0_cursor", {bus.cur_y, bus.cur_x}, {5'd3, 7'd0});
    for (int i = 0; i < 4; i++) send(7'h61);
    send(7'h08);
    chk("bs_write", {bus.we, bus.addr_w, bus.din}, {1'b1, 5'd3, 7'd3, 7'h20});
    chk("bs_cursor", {bus.cur_y, bus.cur_x}, {5'd3, 7'd3});
    send(7'h7F);
    chk("del_nowrite", {31'b0, bus.we}, 32'h0);
    chk("del_cursor", {bus.cur_y, bus.cur_x}, {5'd3, 7'd3});

    // FF at (10,7), then reset in the middle of the screen clear.
    for (int i = 0; i < 4; i++) send(7'h0A);
    for (int i = 0; i < 10; i++) send(7'h7A);
    chk("pre_ff_cursor", {bus.cur_y, bus.cur_x}, {5'd7, 7'd10});
    send(7'h0C);
    chk("ff_cursor", {bus.cur_y, bus.cur_x}, 32'h0);
    chk("ff_busy_ready", {bus.busy, bus.char_ready}, {1'b1, 1'b0});
    repeat (99) @(negedge clk);
    do_reset(2);
    wait_ready();

    // Random stream.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70) ch = 7'($urandom_range(32, 126));
      else if (r < 78) ch = 7'h0D;
      else if (r < 84) ch = 7'h0A;
      else if (r < 92) ch = 7'h08;
      else if (r < 98) begin
        ch = 7'($urandom_range(0, 31));
        if (ch == 7'h08 || ch == 7'h0A || ch == 7'h0C || ch == 7'h0D) ch = 7'h7F;
      end else ch = 7'h0C;
      send(ch);
    end
    wait_ready();
    @(negedge clk);

    diff = 0;
    for (int y = 0; y < Rows; y++)
      for (int x = 0; x < Cols; x++) if (ram[y * 128 + x] !== scr[y * 128 + x]) diff++;
    chk("screen_contents", diff, 0);
    chk("pending_writes", expq.size(), 0);
    chk("out_of_range_writes", n_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
